vga_sync_to_count: RTL and testbench

- Receiver-side counterpart to the VGA sync pulse generator.
- Inputs: raw HSync/VSync, which are active-high during the active region.
- Rebuilds column/row counters from the sync edges, checks frame timing and reports lock.
- Sits between a sync source and downstream pixel/graphics logic. Re-emits the syncs delayed by one cycle so that syncs and counts stay aligned.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 32 +++
 rtl/vga_sync_to_count.sv | 129 ++++++++++++
 tb/tb_vga_sync_to_count.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg : shared VGA timing defaults and the receiver lock-state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int unsigned c_TOTAL_COLS  = 800;
  localparam int unsigned c_TOTAL_ROWS  = 525;
  localparam int unsigned c_ACTIVE_COLS = 640;
  localparam int unsigned c_ACTIVE_ROWS = 480;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGN    = 2'd1,
    LOCKED   = 2'd2
  } t_Sync_State;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect : one-cycle registered copy of a sync plus rise/fall pulses
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sync,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall
);

  logic r_Sync;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync <= 1'b0;
    end else begin
      r_Sync <= i_Sync;
    end
  end

  assign o_Sync = r_Sync;
  assign o_Rise = i_Sync & ~r_Sync;
  assign o_Fall = ~i_Sync & r_Sync;

endmodule

`default_nettype wire

// File: rtl/vga_sync_to_count.sv
// ---------------------------------------------------------------------------
// vga_sync_to_count : rebuilds column/row counts from active-high syncs and
// reports lock. Define VGA_SYNC_CHECK_EN to enable frame-timing checks.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_sync_to_count
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_COLS  = c_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS  = c_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS = c_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = c_ACTIVE_ROWS
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_Locked,
  output logic       o_Sync_Err
);

  localparam logic [9:0] c_COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] c_ROW_LAST = 10'(TOTAL_ROWS - 1);

  logic        w_HSync_Rise, w_HSync_Fall, w_VSync_Rise, w_VSync_Fall;
  logic        w_Viol;
  logic        w_unused;
  t_Sync_State r_State, w_State_Next;
  logic [9:0]  r_Col, r_Row, w_Col_Next, w_Row_Next;
  logic        r_Frame_Start, w_Frame_Start_Next;
  logic        r_Sync_Err, w_Sync_Err_Next;

  sync_edge_detect u_hsync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sync  (i_HSync),
    .o_Sync  (o_HSync),
    .o_Rise  (w_HSync_Rise),
    .o_Fall  (w_HSync_Fall)
  );

  sync_edge_detect u_vsync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sync  (i_VSync),
    .o_Sync  (o_VSync),
    .o_Rise  (w_VSync_Rise),
    .o_Fall  (w_VSync_Fall)
  );

`ifdef VGA_SYNC_CHECK_EN
  // The count lags the source by one cycle, so the HSync fall is seen while
  // the count still shows the last visible column.
  localparam logic [9:0] c_COL_VIS_LAST = 10'(ACTIVE_COLS - 1);

  assign w_Viol = (r_State != UNLOCKED) &&
                  ((w_HSync_Rise && (r_Col != c_COL_LAST)) ||
                   (w_HSync_Fall && (r_Col != c_COL_VIS_LAST)) ||
                   (w_VSync_Rise && ((r_Row != c_ROW_LAST) || (r_Col != c_COL_LAST))));
  assign w_unused = ^{w_VSync_Fall, 10'(ACTIVE_ROWS)};
`else
  assign w_Viol   = 1'b0;
  assign w_unused = ^{w_HSync_Rise, w_HSync_Fall, w_VSync_Fall,
                      10'(ACTIVE_COLS), 10'(ACTIVE_ROWS)};
`endif

  always_comb begin
    w_State_Next       = r_State;
    w_Col_Next         = r_Col;
    w_Row_Next         = r_Row;
    w_Frame_Start_Next = 1'b0;
    w_Sync_Err_Next    = 1'b0;

    if (w_Viol) begin
      w_State_Next    = UNLOCKED;
      w_Col_Next      = '0;
      w_Row_Next      = '0;
      w_Sync_Err_Next = 1'b1;
    end else if (w_VSync_Rise) begin
      w_Col_Next         = '0;
      w_Row_Next         = '0;
      w_Frame_Start_Next = 1'b1;
`ifdef VGA_SYNC_CHECK_EN
      w_State_Next = (r_State == UNLOCKED) ? ALIGN : LOCKED;
`else
      w_State_Next = LOCKED;
`endif
    end else if (r_State != UNLOCKED) begin
      if (r_Col == c_COL_LAST) begin
        w_Col_Next = '0;
        w_Row_Next = (r_Row == c_ROW_LAST) ? 10'd0 : r_Row + 10'd1;
      end else begin
        w_Col_Next = r_Col + 10'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State       <= UNLOCKED;
      r_Col         <= '0;
      r_Row         <= '0;
      r_Frame_Start <= 1'b0;
      r_Sync_Err    <= 1'b0;
    end else begin
      r_State       <= w_State_Next;
      r_Col         <= w_Col_Next;
      r_Row         <= w_Row_Next;
      r_Frame_Start <= w_Frame_Start_Next;
      r_Sync_Err    <= w_Sync_Err_Next;
    end
  end

  assign o_Col_Count   = r_Col;
  assign o_Row_Count   = r_Row;
  assign o_Frame_Start = r_Frame_Start;
  assign o_Sync_Err    = r_Sync_Err;
  assign o_Locked      = (r_State == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_to_count.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_to_count : directed + randomized bench with a frame-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_sync_to_count;

  localparam int TC    = 40;
  localparam int AC    = 32;
  localparam int TR    = 12;
  localparam int AR    = 8;
  localparam int FRAME = TC * TR;
`ifdef VGA_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int LOCK_N = CHK ? 2 : 1;

  logic       clk;
  logic       i_Rst_L, i_HSync, i_VSync;
  logic       o_HSync, o_VSync, o_Frame_Start, o_Locked, o_Sync_Err;
  logic [9:0] o_Col_Count, o_Row_Count;
  logic [26:0] w_obs;

  int total = 0;
  int bad   = 0;
  int g_col, g_row;
  bit m_ph, m_pv, m_fs, m_err;
  int m_frames, m_n;

  assign w_obs = {o_HSync, o_VSync, o_Col_Count, o_Row_Count,
                  o_Frame_Start, o_Locked, o_Sync_Err};

  vga_sync_to_count #(
    .TOTAL_COLS  (TC),
    .TOTAL_ROWS  (TR),
    .ACTIVE_COLS (AC),
    .ACTIVE_ROWS (AR)
  ) u_dut (
    .i_Clk         (clk),
    .i_Rst_L       (i_Rst_L),
    .i_HSync       (i_HSync),
    .i_VSync       (i_VSync),
    .o_HSync       (o_HSync),
    .o_VSync       (o_VSync),
    .o_Col_Count   (o_Col_Count),
    .o_Row_Count   (o_Row_Count),
    .o_Frame_Start (o_Frame_Start),
    .o_Locked      (o_Locked),
    .o_Sync_Err    (o_Sync_Err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: frames = number of accepted frame starts since the last loss of
  // tracking; n = cycles elapsed since the counts were last loaded.
  task automatic model_reset();
    m_ph = 0; m_pv = 0; m_fs = 0; m_err = 0; m_frames = 0; m_n = 0;
  endtask

  function automatic int mcol();
    return (m_frames > 0) ? (m_n % TC) : 0;
  endfunction

  function automatic int mrow();
    return (m_frames > 0) ? ((m_n / TC) % TR) : 0;
  endfunction

  task automatic model_step(input logic h, input logic v);
    bit rh, fh, rv, viol;
    rh = h && !m_ph;
    fh = !h && m_ph;
    rv = v && !m_pv;
    viol = CHK && (m_frames > 0) &&
           ((rh && mcol() != TC - 1) || (fh && mcol() != AC - 1) ||
            (rv && (mcol() != TC - 1 || mrow() != TR - 1)));
    m_fs = 0; m_err = 0;
    if (viol) begin
      m_frames = 0; m_n = 0; m_err = 1;
    end else if (rv) begin
      m_frames++; m_n = 0; m_fs = 1;
    end else if (m_frames > 0) begin
      m_n++;
    end
    m_ph = h; m_pv = v;
  endtask

  task automatic chk_stream();
    logic [26:0] exp;
    exp = {m_ph, m_pv, 10'(mcol()), 10'(mrow()), m_fs, (m_frames >= LOCK_N), m_err};
    chk("stream", {5'b0, w_obs}, {5'b0, exp});
  endtask

  task automatic tick(input logic h, input logic v);
    i_HSync = h; i_VSync = v;
    @(posedge clk);
    model_step(h, v);
    #1;
    chk_stream();
  endtask

  task automatic gen_adv();
    if (g_col == TC - 1) begin
      g_col = 0;
      g_row = (g_row == TR - 1) ? 0 : g_row + 1;
    end else begin
      g_col++;
    end
  endtask

  task automatic gen_tick();
    tick(logic'(g_col < AC), logic'(g_row < AR));
    gen_adv();
  endtask

  task automatic gen_to(input int c, input int r);
    for (int i = 0; i < FRAME + TC && !(g_col == c && g_row == r); i++) gen_tick();
  endtask

  task automatic reset_cycles(input int n, input bit adv);
    i_Rst_L = 1'b0;
    model_reset();
    #1;
    chk("reset_async", {5'b0, w_obs}, 32'd0);
    for (int i = 0; i < n; i++) begin
      i_HSync = adv ? logic'(g_col < AC) : 1'b0;
      i_VSync = adv ? logic'(g_row < AR) : 1'b0;
      @(posedge clk);
      #1;
      chk("reset_hold", {5'b0, w_obs}, 32'd0);
      if (adv) gen_adv();
    end
    i_Rst_L = 1'b1;
  endtask

  initial begin
    int lock_k, errs, pc, pr, rs, rr;
    bit glitch;
    i_Rst_L = 1'b1; i_HSync = 1'b0; i_VSync = 1'b0;
    g_col = 0; g_row = 0;
    #2;

    // Clean acquisition from reset with the generator starting at (0,0)
    reset_cycles(3, 1'b0);
    lock_k = -1; errs = 0;
    for (int k = 0; k < 2 * FRAME + 20; k++) begin
      pc = g_col; pr = g_row;
      gen_tick();
      if (o_Locked && lock_k < 0) lock_k = k;
      if (o_Sync_Err) errs++;
      if (pc == AC - 1 && pr == AR - 1) begin
        chk("spot_col", 32'(o_Col_Count), AC - 1);
        chk("spot_row", 32'(o_Row_Count), AR - 1);
        chk("spot_hs_high", 32'(o_HSync), 1);
      end
      if (pc == AC && pr == AR - 1) chk("spot_hs_low", 32'(o_HSync), 0);
    end
    chk("lock_rise_tick", lock_k, CHK ? FRAME : 0);
    chk("clean_no_err", errs, 0);

    // Stretch one line by a cycle while locked
    rs = $urandom_range(1, TR - 3);
    gen_to(TC - 1, rs);
    tick(logic'(g_col < AC), logic'(g_row < AR));
    errs = 0;
    for (int k = 0; k < TC + 5; k++) begin
      gen_tick();
      if (o_Sync_Err) begin
        errs++;
        chk("err_drops_lock", 32'(o_Locked), 0);
      end
    end
    chk("stretch_err_cnt", errs, CHK ? 1 : 0);
    chk("stretch_locked", 32'(o_Locked), CHK ? 0 : 1);
    gen_to(0, 0);
    for (int k = 0; k < 2 * FRAME + 1; k++) gen_tick();
    chk("relock", 32'(o_Locked), 1);

    // Reset mid-frame while VSync is high
    rr = $urandom_range(2, AR - 2);
    gen_to($urandom_range(0, TC - 1), rr);
    reset_cycles(3, 1'b1);
    gen_tick();
    chk("rst_frame_start", 32'(o_Frame_Start), 1);
    chk("rst_counts", {12'd0, o_Col_Count, o_Row_Count}, 32'd0);
    gen_to(0, 0);
    for (int k = 0; k < 2 * FRAME + 1; k++) gen_tick();
    chk("rst_relock", 32'(o_Locked), 1);

    // VSync held high from reset release
    reset_cycles(2, 1'b0);
    g_col = $urandom_range(1, AC - 3); g_row = 0;
    errs = 0;
    for (int k = 0; k < 2 * TC; k++) begin
      tick(logic'(g_col < AC), 1'b1);
      gen_adv();
      if (k == 0) chk("vhold_first_fs", 32'(o_Frame_Start), 1);
      if (o_Sync_Err) errs++;
    end
    chk("vhold_err_cnt", errs, CHK ? 1 : 0);
    chk("vhold_locked", 32'(o_Locked), CHK ? 0 : 1);

    // Randomized traffic: generator with sparse glitches, then raw noise
    reset_cycles(2, 1'b0);
    g_col = 0; g_row = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      glitch = (k > FRAME + 2) && ($urandom_range(0, 63) == 0);
      tick(logic'(g_col < AC) ^ glitch, logic'(g_row < AR));
      gen_adv();
    end
    for (int k = 0; k < 200; k++) tick(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
